// File: rtl/fp_div_queue_pkg.sv
// Shared definitions for the queued FP divider: default widths, operand/result
// class encodings, FSM state encoding and the special-operand resolver.
package fp_div_queue_pkg;

  localparam int MANT_W_DEF = 53;
  localparam int SP_W_DEF   = 24;
  localparam int EXP_W_DEF  = 11;
  localparam int DEPTH_DEF  = 4;
  localparam int TAG_W_DEF  = 2;

  localparam logic [2:0] FLG_NORM = 3'b000;
  localparam logic [2:0] FLG_ZERO = 3'b001;
  localparam logic [2:0] FLG_INF  = 3'b010;
  localparam logic [2:0] FLG_NAN  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_NORM = 2'd3
  } state_e;

  // A "normal" operand whose mantissa is zero is resolved as a zero.
  function automatic logic [2:0] resolve_special(input logic [2:0] fa, input logic [2:0] fb,
                                                 input logic a_mzero, input logic b_mzero);
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    a_nan  = (fa == FLG_NAN);
    a_inf  = (fa == FLG_INF);
    a_zero = (fa == FLG_ZERO) || ((fa == FLG_NORM) && a_mzero);
    b_nan  = (fb == FLG_NAN);
    b_inf  = (fb == FLG_INF);
    b_zero = (fb == FLG_ZERO) || ((fb == FLG_NORM) && b_mzero);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      resolve_special = FLG_NAN;
    else if (a_inf || b_zero)
      resolve_special = FLG_INF;
    else if (a_zero || b_inf)
      resolve_special = FLG_ZERO;
    else
      resolve_special = FLG_NORM;
  endfunction

endpackage

// File: rtl/fp_div_queue_if.sv
// Request and result handshake bundle between the issue logic and the divider queue.
interface fp_div_queue_if #(
  parameter int MANT_W = fp_div_queue_pkg::MANT_W_DEF,
  parameter int EXP_W  = fp_div_queue_pkg::EXP_W_DEF,
  parameter int TAG_W  = fp_div_queue_pkg::TAG_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_tag;
  logic [MANT_W-1:0] in_a;
  logic [MANT_W-1:0] in_b;
  logic [EXP_W-1:0]  exp_a;
  logic [EXP_W-1:0]  exp_b;
  logic              sgn_a;
  logic              sgn_b;
  logic              mode;
  logic [2:0]        flg_a;
  logic [2:0]        flg_b;

  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [MANT_W-1:0] out_res;
  logic [EXP_W-1:0]  out_exp;
  logic              out_sgn;
  logic [2:0]        out_flg;

  modport master (
    output in_valid, in_tag, in_a, in_b, exp_a, exp_b, sgn_a, sgn_b, mode, flg_a, flg_b,
    output out_ready,
    input  in_ready, out_valid, out_tag, out_res, out_exp, out_sgn, out_flg
  );

  modport slave (
    input  in_valid, in_tag, in_a, in_b, exp_a, exp_b, sgn_a, sgn_b, mode, flg_a, flg_b,
    input  out_ready,
    output in_ready, out_valid, out_tag, out_res, out_exp, out_sgn, out_flg
  );

endinterface

// File: rtl/fp_div_queue_div_iter_core.sv
// Restoring radix-2 divider: one quotient bit per cycle for n_iter cycles after start.
// done_o flags the final iteration; q_o is complete on the following cycle.
module div_iter_core #(
  parameter int W     = 53,
  parameter int CNT_W = $clog2(W + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_iter_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic             done_o,
  output logic [W:0]       q_o
);

  logic [W:0]       r_q, r_d;
  logic [W:0]       q_q, q_d;
  logic [W-1:0]     b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ge;
  logic [W:0]       sel;

  always_comb begin
    ge  = (r_q >= {1'b0, b_q});
    sel = ge ? (r_q - {1'b0, b_q}) : r_q;
    r_d = sel << 1;
    q_d = {q_q[W-1:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      q_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      r_q   <= {1'b0, a_i};
      q_q   <= '0;
      b_q   <= b_i;
      cnt_q <= n_iter_i;
    end else if (cnt_q != '0) begin
      r_q   <= r_d;
      q_q   <= q_d;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));
  assign q_o    = q_q;

endmodule

// File: rtl/fp_div_queue.sv
// Tagged FP divide queue: request FIFO feeding an in-order iterative mantissa divider
// with a registered result stage.
//   state | meaning
//   IDLE  | wait for a queued request and a free output register; pop on exit
//   LOAD  | classify operands; write special result or start the divider
//   ITER  | divider produces one quotient bit per cycle
//   NORM  | normalise quotient, write output register
module fp_div_queue import fp_div_queue_pkg::*; #(
  parameter int MANT_W = MANT_W_DEF,
  parameter int SP_W   = SP_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fp_div_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   busy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MANT_W + 2);
  localparam int LOW_W = MANT_W - SP_W;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] N_DP    = CNT_W'(MANT_W + 1);
  localparam logic [CNT_W-1:0] N_SP    = CNT_W'(SP_W + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [MANT_W-1:0] a;
    logic [MANT_W-1:0] b;
    logic [EXP_W-1:0]  ea;
    logic [EXP_W-1:0]  eb;
    logic              sa;
    logic              sb;
    logic              mode;
    logic [2:0]        fa;
    logic [2:0]        fb;
  } req_t;

  req_t             mem [DEPTH];
  req_t             req_in, cur_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             in_ready, push, pop;

  state_e state_q, state_d;

  logic              out_valid_q, out_sgn_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic [MANT_W-1:0] out_res_q;
  logic [EXP_W-1:0]  out_exp_q;
  logic [2:0]        out_flg_q;

  logic              out_free, wr, core_start, core_done;
  logic [MANT_W-1:0] wr_res, norm_res, core_a, core_b;
  logic [EXP_W-1:0]  wr_exp, norm_exp, exp_diff;
  logic [2:0]        wr_flg, spec_flg;
  logic              a_mzero, b_mzero;
  logic [MANT_W:0]   core_q;

  assign req_in = '{tag: bus.in_tag, a: bus.in_a, b: bus.in_b, ea: bus.exp_a, eb: bus.exp_b,
                    sa: bus.sgn_a, sb: bus.sgn_b, mode: bus.mode, fa: bus.flg_a, fb: bus.flg_b};

  assign in_ready = (count_q != DEPTH_C);
  assign push     = bus.in_valid && in_ready;
  assign out_free = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= req_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cur_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        cur_q    <= mem[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // SP operands use the top SP_W bits, right-aligned into the divider.
  always_comb begin
    if (cur_q.mode) begin
      core_a  = cur_q.a;
      core_b  = cur_q.b;
      a_mzero = (cur_q.a == '0);
      b_mzero = (cur_q.b == '0);
    end else begin
      core_a  = {{LOW_W{1'b0}}, cur_q.a[MANT_W-1 -: SP_W]};
      core_b  = {{LOW_W{1'b0}}, cur_q.b[MANT_W-1 -: SP_W]};
      a_mzero = (cur_q.a[MANT_W-1 -: SP_W] == '0);
      b_mzero = (cur_q.b[MANT_W-1 -: SP_W] == '0);
    end
    spec_flg = resolve_special(cur_q.fa, cur_q.fb, a_mzero, b_mzero);
  end

  div_iter_core #(.W(MANT_W), .CNT_W(CNT_W)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (core_start),
    .n_iter_i (cur_q.mode ? N_DP : N_SP),
    .a_i      (core_a),
    .b_i      (core_b),
    .done_o   (core_done),
    .q_o      (core_q)
  );

  always_comb begin
    exp_diff = cur_q.ea - cur_q.eb;
    if (cur_q.mode) begin
      if (core_q[MANT_W]) begin
        norm_res = core_q[MANT_W:1];
        norm_exp = exp_diff;
      end else begin
        norm_res = core_q[MANT_W-1:0];
        norm_exp = exp_diff - EXP_W'(1);
      end
    end else begin
      if (core_q[SP_W]) begin
        norm_res = {core_q[SP_W:1], {LOW_W{1'b0}}};
        norm_exp = exp_diff;
      end else begin
        norm_res = {core_q[SP_W-1:0], {LOW_W{1'b0}}};
        norm_exp = exp_diff - EXP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    core_start = 1'b0;
    wr         = 1'b0;
    wr_res     = '0;
    wr_exp     = '0;
    wr_flg     = FLG_NORM;
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && out_free) begin
          pop     = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (spec_flg != FLG_NORM) begin
          wr      = 1'b1;
          wr_flg  = spec_flg;
          state_d = ST_IDLE;
        end else begin
          core_start = 1'b1;
          state_d    = ST_ITER;
        end
      end
      ST_ITER: begin
        if (core_done) state_d = ST_NORM;
      end
      ST_NORM: begin
        wr      = 1'b1;
        wr_res  = norm_res;
        wr_exp  = norm_exp;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only one op is in flight and it is popped only into a free register,
  // so a write never collides with a still-pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_res_q   <= '0;
      out_exp_q   <= '0;
      out_sgn_q   <= 1'b0;
      out_flg_q   <= '0;
    end else if (wr) begin
      out_valid_q <= 1'b1;
      out_tag_q   <= cur_q.tag;
      out_res_q   <= wr_res;
      out_exp_q   <= wr_exp;
      out_sgn_q   <= cur_q.sa ^ cur_q.sb;
      out_flg_q   <= wr_flg;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_sgn   = out_sgn_q;
  assign bus.out_flg   = out_flg_q;
  assign count_o       = count_q;
  assign busy_o        = (state_q != ST_IDLE) || (count_q != '0) || out_valid_q;

endmodule

// File: tb/tb_fp_div_queue.sv
// Directed bench for fp_div_queue: DP/SP quotients, specials, FIFO back-pressure and reset abort.
module tb_fp_div_queue;
  import fp_div_queue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fp_div_queue_if #(.MANT_W(53), .EXP_W(11), .TAG_W(2)) bus ();
  logic [2:0] count;
  logic       busy;

  fp_div_queue #(.MANT_W(53), .SP_W(24), .EXP_W(11), .DEPTH(4), .TAG_W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .count_o (count),
    .busy_o  (busy)
  );

  int checks = 0;
  int errors = 0;
  int t0 = 0;

  localparam logic [52:0] ONE   = 53'h10000000000000;
  localparam logic [52:0] ONE_5 = 53'h18000000000000;
  localparam logic [52:0] FIVE  = 53'h14000000000000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] tag, input logic [52:0] a, input logic [52:0] b,
                       input logic [10:0] ea, input logic [10:0] eb, input logic sa,
                       input logic sb, input logic md, input logic [2:0] fa, input logic [2:0] fb);
    bus.in_valid = 1'b1;
    bus.in_tag   = tag;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.exp_a    = ea;
    bus.exp_b    = eb;
    bus.sgn_a    = sa;
    bus.sgn_b    = sb;
    bus.mode     = md;
    bus.flg_a    = fa;
    bus.flg_b    = fb;
  endtask

  task automatic push(input string name, input logic [1:0] tag, input logic [52:0] a,
                      input logic [52:0] b, input logic [10:0] ea, input logic [10:0] eb,
                      input logic sa, input logic sb, input logic md,
                      input logic [2:0] fa, input logic [2:0] fb);
    chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    drive(tag, a, b, ea, eb, sa, sb, md, fa, fb);
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int lat);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, 64'(cyc - t0), 64'(lat));
  endtask

  task automatic check_out(input string name, input logic [1:0] tag, input logic [52:0] res,
                           input logic [10:0] ex, input logic sgn, input logic [2:0] flg);
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_tag"},   64'(bus.out_tag), 64'(tag));
    chk({name, "_res"},   64'(bus.out_res), 64'(res));
    chk({name, "_exp"},   64'(bus.out_exp), 64'(ex));
    chk({name, "_sgn"},   64'(bus.out_sgn), 64'(sgn));
    chk({name, "_flg"},   64'(bus.out_flg), 64'(flg));
  endtask

  task automatic pop_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_tags [6];
    int k;
    int n;
    logic drop;

    drive(2'd0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, FLG_NORM, FLG_NORM);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count",     64'(count), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("rst_out_res",   64'(bus.out_res), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // DP 1.5 / 1.0
    push("dp15", 2'd0, ONE_5, ONE, 11'd3, 11'd1, 1'b0, 1'b1, 1'b1, FLG_NORM, FLG_NORM);
    chk("dp15_busy", 64'(busy), 64'd1);
    wait_out("dp15", 57);
    check_out("dp15", 2'd0, 53'h18000000000000, 11'd2, 1'b1, FLG_NORM);
    pop_out();
    chk("dp15_popped", 64'(bus.out_valid), 64'd0);

    // DP 1.0 / 1.5
    push("dp10", 2'd1, ONE, ONE_5, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, FLG_NORM, FLG_NORM);
    wait_out("dp10", 57);
    check_out("dp10", 2'd1, 53'h15555555555555, 11'h7FF, 1'b0, FLG_NORM);
    pop_out();

    // SP 1.0 / 1.5
    push("sp10", 2'd2, ONE, ONE_5, 11'd0, 11'd0, 1'b1, 1'b0, 1'b0, FLG_NORM, FLG_NORM);
    wait_out("sp10", 28);
    check_out("sp10", 2'd2, 53'h15555540000000, 11'h7FF, 1'b1, FLG_NORM);
    pop_out();

    // reset in the middle of an iteration
    push("abort", 2'd3, ONE, ONE_5, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, FLG_NORM, FLG_NORM);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_out_res",   64'(bus.out_res), 64'd0);
    chk("abort_out_exp",   64'(bus.out_exp), 64'd0);
    chk("abort_out_tag",   64'(bus.out_tag), 64'd0);
    chk("abort_out_sgn",   64'(bus.out_sgn), 64'd0);
    chk("abort_busy",      64'(busy), 64'd0);
    chk("abort_count",     64'(count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push("post_rst", 2'd1, ONE_5, ONE, 11'd7, 11'd2, 1'b1, 1'b0, 1'b1, FLG_NORM, FLG_NORM);
    wait_out("post_rst", 57);
    check_out("post_rst", 2'd1, 53'h18000000000000, 11'd5, 1'b1, FLG_NORM);
    pop_out();

    // special operands
    push("zz", 2'd1, '0, '0, 11'd5, 11'd3, 1'b1, 1'b1, 1'b1, FLG_ZERO, FLG_ZERO);
    wait_out("zz", 2);
    check_out("zz", 2'd1, '0, '0, 1'b0, FLG_NAN);
    pop_out();

    push("iz", 2'd2, ONE, '0, 11'd5, 11'd3, 1'b0, 1'b1, 1'b1, FLG_INF, FLG_ZERO);
    wait_out("iz", 2);
    check_out("iz", 2'd2, '0, '0, 1'b1, FLG_INF);
    pop_out();

    push("fi", 2'd3, FIVE, ONE, 11'd2, 11'd0, 1'b0, 1'b0, 1'b1, FLG_NORM, FLG_INF);
    wait_out("fi", 2);
    check_out("fi", 2'd3, '0, '0, 1'b0, FLG_ZERO);
    pop_out();

    push("bz", 2'd0, ONE_5, '0, 11'd4, 11'd1, 1'b1, 1'b0, 1'b0, FLG_NORM, FLG_NORM);
    wait_out("bz", 2);
    check_out("bz", 2'd0, '0, '0, 1'b1, FLG_INF);
    pop_out();

    // back-pressure: five accepted, sixth held off
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 64'(bus.in_ready), 64'd1);
      drive(2'(i), '0, '0, 11'd1, 11'd1, 1'(i & 1), 1'b0, 1'b1, FLG_ZERO, FLG_ZERO);
      @(posedge clk);
      #1;
    end
    drive(2'd1, '0, '0, 11'd1, 11'd1, 1'b1, 1'b0, 1'b1, FLG_ZERO, FLG_ZERO);
    for (int i = 0; i < 3; i++) begin
      chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_full_count", 64'(count), 64'd4);
      chk("bp_stall_tag",  64'(bus.out_tag), 64'd0);
      chk("bp_stall_flg",  64'(bus.out_flg), 64'(FLG_NAN));
      chk("bp_stall_res",  64'(bus.out_res), 64'd0);
      chk("bp_stall_vld",  64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;
    end

    exp_tags[0] = 2'd0; exp_tags[1] = 2'd1; exp_tags[2] = 2'd2;
    exp_tags[3] = 2'd3; exp_tags[4] = 2'd0; exp_tags[5] = 2'd1;
    bus.out_ready = 1'b1;
    k = 0;
    n = 0;
    while (k < 6 && n < 200) begin
      drop = bus.in_valid && bus.in_ready;
      if (bus.out_valid === 1'b1) begin
        chk("bp_order_tag", 64'(bus.out_tag), 64'(exp_tags[k]));
        chk("bp_order_sgn", 64'(bus.out_sgn), 64'(k & 1));
        chk("bp_order_flg", 64'(bus.out_flg), 64'(FLG_NAN));
        k++;
      end
      @(posedge clk);
      #1;
      if (drop) bus.in_valid = 1'b0;
      n++;
    end
    bus.out_ready = 1'b0;
    chk("bp_received", 64'(k), 64'd6);
    chk("bp_in_valid_taken", 64'(bus.in_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_drain_count", 64'(count), 64'd0);
    chk("bp_drain_busy",  64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_div_queue.md
# fp_div_queue

Buffered, parametrised successor to the FP divider wrapper. Accepts tagged divide requests over a valid/ready handshake into a DEPTH-entry FIFO and runs them in order through an iterative radix-2 mantissa divider. Special operands (zero/inf/NaN) resolve without iteration. Results are returned through a registered valid/ready output with tag, exponent, sign and result flags. The block sits between the FPU issue logic and the result normaliser/rounder.

## Interface
- MANT_W, 53: mantissa width incl. hidden bit; operands normalised (MSB=1) unless flagged zero.
- SP_W, 24: single-precision mantissa width, MSB-aligned in the MANT_W field.
- EXP_W, 11: unbiased two's-complement exponent width.
- DEPTH, 4: request FIFO depth (power of 2, ≥2).
- TAG_W, 2: request tag width.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid / in_ready  in/out  1  request handshake; in_ready = (count < DEPTH), from registered count.
- in_tag  in  TAG_W  request tag.
- in_a, in_b  in  MANT_W  dividend, divisor mantissas.
- exp_a, exp_b  in  EXP_W  exponents.
- sgn_a, sgn_b  in  1  signs.
- mode  in  1  0 = SP, 1 = DP.
- flg_a, flg_b  in  3  operand class: 000 normal, 001 zero, 010 inf, 100 NaN.
- out_valid / out_ready  out/in  1  result handshake.
- out_tag  out  TAG_W; out_res  out  MANT_W; out_exp  out  EXP_W; out_sgn  out  1; out_flg  out  3 (same encoding).
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  FSM not IDLE, or count≠0, or out_valid.

## Operation
- Push on in_valid&&in_ready. A push into a full FIFO cannot occur, even if a pop happens in the same cycle.
- FSM states: IDLE, LOAD, ITER, NORM.
  - IDLE→LOAD when count≠0 and the output register is free (¬out_valid, or out_valid&&out_ready this cycle). The FIFO pops on this edge.
  - LOAD: classify the operand and write the result if special; next IDLE. Otherwise initialise the remainder = A and load the iteration counter with N = (mode ? MANT_W+1 : SP_W+1); next ITER.
  - ITER: one quotient bit per cycle (restoring: r = r−B if r≥B, shift). After N cycles go to NORM.
  - NORM: write the output register; next IDLE.
- Mantissa: Q = floor(A·2^W/B), where W = MANT_W (DP) or SP_W (SP). SP uses the top SP_W bits of A and B.
  - If Q[W]=1: res = Q[W:1], exp = exp_a−exp_b.
  - Else: res = Q[W−1:0], exp = exp_a−exp_b−1.
  - Exponent arithmetic is modular in EXP_W.
  - Truncate; no rounding.
  - SP result is MSB-aligned with the low MANT_W−SP_W bits set to 0.
- Sign: sgn_a^sgn_b for every result, including NaN.
- Special priority, in order:
  1. NaN if either operand is NaN, zero/zero, or inf/inf.
  2. inf if A is inf or B is zero.
  3. zero if A is zero or B is inf.
  - Special results have res=0 and exp=0.
  - A normal B with in_b==0 is treated as zero.
- Results leave in request order. out_* hold steady while out_valid&&¬out_ready.
- Reset: FIFO empty, count=0, FSM IDLE, out_valid=0, out_res/out_exp/out_tag/out_flg/out_sgn=0, busy=0. Reset asserted mid-operation aborts the operation; no partial result appears.

## Timing
- Request accepted at edge t0, with the FIFO empty, core IDLE and output free:
  - Special result: out_valid rises after edge t0+2.
  - Normal result: out_valid rises after edge t0+N+3. DP (MANT_W=53) → t0+57; SP → t0+28.
- Sustained throughput is one operation per N+3 cycles; a special operation costs 2 cycles.
- If out_ready stays low, the core finishes at most one further op into IDLE-wait (it does not load), and the FIFO keeps accepting until full.

## Structure
- Shared header holds the flag encodings (FLG_NORM, FLG_ZERO, FLG_INF, FLG_NAN), the FSM state encoding and the default widths.
- Sub-module div_iter_core: restoring radix-2 divider with start, n_iter, a, b inputs and done, q outputs.
- The FIFO and FSM stay in fp_div_queue.

## Test plan
- DP 1.5/1.0 (in_a=0x18000000000000, in_b=0x10000000000000, exp 3/1, signs 0/1) → res 0x18000000000000, exp 2, sgn 1, flg 000, out_valid at t0+57.
- DP 1.0/1.5 (0x10000000000000 / 0x18000000000000, exp 0/0) → res 0x15555555555555, exp −1 (0x7FF).
- SP 1.0/1.5 (mode=0, same inputs) → res 0x15555540000000, exp −1, out_valid at t0+28.
- Specials: zero/zero → NaN; inf/zero → inf; 5/inf → zero. Each with res=0, at t0+2.
- Push 6 tagged ops with out_ready=0 → in_ready drops at count=4. Then release out_ready → tags return in order 0,1,2,3,…, and outputs stay stable while stalled.
- Assert rst low mid-ITER → all outputs zero immediately. After release, a new op completes with correct latency and no stale result.
